// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package writeback_arbiter_pkg;

    localparam int WB_THREAD_IDX_WIDTH = 2;
    localparam int WB_VECTOR_LANES     = 16;
    localparam int WB_REG_WIDTH        = 5;

    // Source slots on the arbiter
    localparam int WB_SRC_SCYCLE = 0;
    localparam int WB_SRC_MCYCLE = 1;
    localparam int WB_SRC_DCACHE = 2;

    // One completed result headed for the register file (default geometry)
    typedef struct packed {
        logic [WB_THREAD_IDX_WIDTH-1:0]  thread_idx;
        logic [WB_REG_WIDTH-1:0]         reg_idx;
        logic                            is_vector;
        logic [WB_VECTOR_LANES-1:0]      mask;
        logic [WB_VECTOR_LANES*32-1:0]   value;
    } wb_request_t;

    // Round-robin successor, wrapping n-1 back to 0
    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// Per-source holding FIFO with bypass head: when empty, the head shows the
// incoming push so it can be granted the same cycle without being stored.
// A push seen while full is dropped even if a pop happens the same cycle.
module wb_arb_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_request_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic [CNT_W-1:0] count,
    output logic             almost_full,
    output logic             full
);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               empty, bypass, do_push, do_pop;

    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign almost_full = (count_q >= CNT_W'(DEPTH - 1));
    assign count       = count_q;
    assign head        = empty ? push_data : mem_q[rd_q];

    // Pointer and occupancy update; a granted bypass touches nothing
    always_comb begin
        bypass  = empty && push && pop;
        do_push = push && !full && !bypass;
        do_pop  = pop && !empty;
        wr_d    = wr_q + PTR_W'(do_push);
        rd_d    = rd_q + PTR_W'(do_pop);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Pointer/count state
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_q] <= push_data;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing the register-file write port among execution
// pipelines. Optional performance counters are built when WB_ARB_PERF_EN is
// defined; without it there are no counters and no perf ports.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int  NUM_SOURCES      = 3,
    parameter int  FIFO_DEPTH       = 4,
    parameter int  THREAD_IDX_WIDTH = WB_THREAD_IDX_WIDTH,
    parameter int  VECTOR_LANES     = WB_VECTOR_LANES,
    // Off only for environments that overflow a FIFO on purpose
    parameter bit  OVF_ASSERT_EN    = 1'b1,
    localparam int SRC_W            = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_SOURCES-1:0]               src_valid,
    input  logic [NUM_SOURCES*THREAD_IDX_WIDTH-1:0] src_thread_idx,
    input  logic [NUM_SOURCES*5-1:0]             src_reg,
    input  logic [NUM_SOURCES-1:0]               src_is_vector,
    input  logic [NUM_SOURCES*VECTOR_LANES-1:0]  src_mask,
    input  logic [NUM_SOURCES*VECTOR_LANES*32-1:0] src_value,
    output logic [NUM_SOURCES-1:0]               src_almost_full,
    output logic                                 wb_en,
    output logic [THREAD_IDX_WIDTH-1:0]          wb_thread_idx,
    output logic                                 wb_is_vector,
    output logic [VECTOR_LANES-1:0]              wb_mask,
    output logic [4:0]                           wb_reg,
    output logic [VECTOR_LANES*32-1:0]           wb_value,
    output logic [SRC_W-1:0]                     wb_source,
`ifdef WB_ARB_PERF_EN
    output logic [NUM_SOURCES*32-1:0]            perf_conflict_cycles,
    output logic [31:0]                          perf_stall_cycles,
`endif
    output logic                                 overflow_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [THREAD_IDX_WIDTH-1:0] thread_idx;
        logic [4:0]                  reg_idx;
        logic                        is_vector;
        logic [VECTOR_LANES-1:0]     mask;
        logic [VECTOR_LANES*32-1:0]  value;
    } req_t;

    req_t                   src_req [NUM_SOURCES];
    req_t                   head    [NUM_SOURCES];
    logic [CNT_W-1:0]       count   [NUM_SOURCES];
    logic [NUM_SOURCES-1:0] eligible, grant, full, ovf_push;
    logic [SRC_W-1:0]       grant_idx;
    logic                   found;
    int                     idx;

    logic [SRC_W-1:0]       rr_q, rr_d;
    logic                   wb_en_q, wb_en_d;
    req_t                   wb_req_q, wb_req_d;
    logic [SRC_W-1:0]       wb_source_q, wb_source_d;
    logic                   overflow_q, overflow_d;

    for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
        assign src_req[i].thread_idx = src_thread_idx[i*THREAD_IDX_WIDTH +: THREAD_IDX_WIDTH];
        assign src_req[i].reg_idx    = src_reg[i*5 +: 5];
        assign src_req[i].is_vector  = src_is_vector[i];
        assign src_req[i].mask       = src_mask[i*VECTOR_LANES +: VECTOR_LANES];
        assign src_req[i].value      = src_value[i*VECTOR_LANES*32 +: VECTOR_LANES*32];
        // A queued head or a same-cycle bypass both compete
        assign eligible[i]           = (count[i] != '0) || src_valid[i];

        wb_arb_fifo #(
            .DEPTH   (FIFO_DEPTH),
            .entry_t (req_t)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .push        (src_valid[i]),
            .push_data   (src_req[i]),
            .pop         (grant[i]),
            .head        (head[i]),
            .count       (count[i]),
            .almost_full (src_almost_full[i]),
            .full        (full[i])
        );
    end

    assign ovf_push = src_valid & full;

    // First eligible source at or after rr_q, wrapping
    always_comb begin
        grant     = '0;
        grant_idx = rr_q;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            idx = (int'(rr_q) + k) % NUM_SOURCES;
            if (!found && eligible[idx]) begin
                found     = 1'b1;
                grant_idx = SRC_W'(idx);
            end
        end
        if (found)
            grant[grant_idx] = 1'b1;
    end

    // Next-state for pointer, write port and sticky error
    always_comb begin
        rr_d        = found ? SRC_W'(wrap_inc(int'(grant_idx), NUM_SOURCES)) : rr_q;
        wb_en_d     = found;
        wb_req_d    = found ? head[grant_idx] : wb_req_q;
        wb_source_d = found ? grant_idx : wb_source_q;
        overflow_d  = overflow_q || (ovf_push != '0);
    end

    // Registered write port and arbiter state
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q        <= '0;
            wb_en_q     <= 1'b0;
            wb_req_q    <= '0;
            wb_source_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            wb_en_q     <= wb_en_d;
            wb_req_q    <= wb_req_d;
            wb_source_q <= wb_source_d;
            overflow_q  <= overflow_d;
        end
    end

    // A dropped result means issue ignored almost_full; flag it in simulation
    always_ff @(posedge clk) begin
        if (!reset && OVF_ASSERT_EN)
            assert (ovf_push == '0)
                else $error("writeback_arbiter: push into full FIFO, sources %b", ovf_push);
    end

    assign wb_en         = wb_en_q;
    assign wb_thread_idx = wb_req_q.thread_idx;
    assign wb_reg        = wb_req_q.reg_idx;
    assign wb_is_vector  = wb_req_q.is_vector;
    assign wb_mask       = wb_req_q.mask;
    assign wb_value      = wb_req_q.value;
    assign wb_source     = wb_source_q;
    assign overflow_err  = overflow_q;

`ifdef WB_ARB_PERF_EN
    logic [NUM_SOURCES-1:0][31:0] conflict_q, conflict_d;
    logic [31:0]                  stall_q, stall_d;

    // Saturating counts of lost arbitration and of back-pressure cycles
    always_comb begin
        for (int i = 0; i < NUM_SOURCES; i++) begin
            conflict_d[i] = conflict_q[i];
            if (eligible[i] && !grant[i] && (conflict_q[i] != '1))
                conflict_d[i] = conflict_q[i] + 32'd1;
        end
        stall_d = stall_q;
        if ((src_almost_full != '0) && (stall_q != '1))
            stall_d = stall_q + 32'd1;
    end

    // Counter state
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q <= '0;
            stall_q    <= '0;
        end else begin
            conflict_q <= conflict_d;
            stall_q    <= stall_d;
        end
    end

    assign perf_conflict_cycles = conflict_q;
    assign perf_stall_cycles    = stall_q;
`endif

endmodule
